// File: rtl/divider_unit_pkg.sv
// Shared rv32m definitions for the divider unit.
//   op_e     : DIV/DIVU/REM/REMU encodings (funct3[1:0])
//   state_e  : divider FSM states, gray-style with IDLE = 000
//   IntMin / AllOnes : RISC-V special-case constants
//   abs32()  : two's-complement magnitude of a 32-bit value
package divider_unit_pkg;

  typedef enum logic [1:0] {
    OpDiv  = 2'b00,
    OpDivu = 2'b01,
    OpRem  = 2'b10,
    OpRemu = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    StIdle   = 3'b000,
    StCheck  = 3'b001,
    StDivide = 3'b011,
    StFix    = 3'b010,
    StDone   = 3'b110
  } state_e;

  localparam logic [31:0] IntMin  = 32'h8000_0000;
  localparam logic [31:0] AllOnes = 32'hFFFF_FFFF;

  // INT_MIN maps to itself, which is the correct unsigned magnitude 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/divider_unit_if.sv
// Divider request/response bundle.
//   div_en_i : level enable, held high for the whole operation
//   op_i     : operation select (op_e)
//   rs1_i    : dividend
//   rs2_i    : divisor
//   result_o : quotient or remainder (registered)
//   busy_o   : high while CHECK/DIVIDE/FIX
//   done_o   : high while DONE
// master = dispatch logic, slave = divider.
interface divider_unit_if;
  import divider_unit_pkg::*;

  logic        div_en_i;
  op_e         op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [31:0] result_o;
  logic        busy_o;
  logic        done_o;

  modport master (
    output div_en_i, op_i, rs1_i, rs2_i,
    input  result_o, busy_o, done_o
  );

  modport slave (
    input  div_en_i, op_i, rs1_i, rs2_i,
    output result_o, busy_o, done_o
  );

endinterface

// File: rtl/divider_unit_div_step.sv
// One radix-2 restoring division iteration (combinational).
//   rem_i / rem_o     : 33-bit partial remainder before / after the step
//   quo_i / quo_o     : quotient register; holds the unconsumed dividend bits
//                       in its upper part, quotient bits fill in from the LSB
//   divisor_i         : divisor magnitude
module divider_unit_div_step (
  input  logic [32:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] divisor_i,
  output logic [32:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] shifted;
  logic [33:0] diff;

  always_comb begin
    // Remainder is always < divisor, so bit 32 of rem_i is zero here.
    shifted = {rem_i[31:0], quo_i[31]};
    diff    = {1'b0, shifted} - {2'b00, divisor_i};
    if (!diff[33]) begin
      rem_o = diff[32:0];
      quo_o = {quo_i[30:0], 1'b1};
    end else begin
      rem_o = shifted;
      quo_o = {quo_i[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider_unit.sv
// Sequential 32-bit RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per clock.
//   clk_i : clock
//   rst_i : asynchronous active-high reset
//   bus   : divider_unit_if.slave (level-enable / sticky-done handshake)
// Normal path: IDLE -> CHECK -> DIVIDE x32 -> FIX -> DONE (done after edge 34).
// Divide-by-zero and signed overflow go CHECK -> DONE directly.
module divider_unit
  import divider_unit_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  divider_unit_if.slave bus
);

  state_e      state_q;
  op_e         op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] dvsr_q;
  logic [31:0] quo_q;
  logic [32:0] rem_q;
  logic [4:0]  cnt_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic [31:0] result_q;

  logic [32:0] step_rem;
  logic [31:0] step_quo;
  logic        is_signed;
  logic        is_rem;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  divider_unit_div_step u_div_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    is_signed = ~op_q[0];
    is_rem    = op_q[1];
    quo_fix   = neg_quo_q ? -quo_q : quo_q;
    rem_fix   = neg_rem_q ? -rem_q[31:0] : rem_q[31:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      op_q      <= OpDiv;
      a_q       <= '0;
      b_q       <= '0;
      dvsr_q    <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else if (!bus.div_en_i) begin
      // Abort or idle; result_q keeps its last value.
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          op_q    <= bus.op_i;
          a_q     <= bus.rs1_i;
          b_q     <= bus.rs2_i;
          state_q <= StCheck;
        end
        StCheck: begin
          if (b_q == '0) begin
            result_q <= is_rem ? a_q : AllOnes;
            state_q  <= StDone;
          end else if (is_signed && (a_q == IntMin) && (b_q == AllOnes)) begin
            result_q <= is_rem ? '0 : IntMin;
            state_q  <= StDone;
          end else begin
            quo_q     <= is_signed ? abs32(a_q) : a_q;
            dvsr_q    <= is_signed ? abs32(b_q) : b_q;
            rem_q     <= '0;
            cnt_q     <= 5'd31;
            neg_quo_q <= is_signed & (a_q[31] ^ b_q[31]);
            neg_rem_q <= is_signed & a_q[31];
            state_q   <= StDivide;
          end
        end
        StDivide: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          if (cnt_q == '0) begin
            state_q <= StFix;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        StFix: begin
          result_q <= is_rem ? rem_fix : quo_fix;
          state_q  <= StDone;
        end
        StDone: begin
          state_q <= StDone;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.result_o = result_q;
  assign bus.busy_o   = (state_q == StCheck) || (state_q == StDivide) || (state_q == StFix);
  assign bus.done_o   = (state_q == StDone);

endmodule

// File: doc/divider_unit.md
# divider_unit

Sequential 32-bit integer divider completing the RV32M accelerator alongside the multiplier. It executes DIV, DIVU, REM and REMU with a radix-2 restoring algorithm, one quotient bit per clock. It uses the same level-enable / sticky-done handshake as the multiplier, so the accelerator's dispatch logic drives both units identically. RISC-V divide-by-zero and signed-overflow cases bypass the iteration loop.

## Interface
- No parameters; datapath width fixed at 32.
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- div_en_i  in  1  enable; held high for the whole operation; low returns the unit to IDLE.
- op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- rs1_i  in  32  dividend.
- rs2_i  in  32  divisor.
- result_o  out  32  quotient or remainder; registered.
- busy_o  out  1  high in CHECK, DIVIDE, FIX.
- done_o  out  1  high in DONE.

## Operation
- One clock; reset is asynchronous and active-high (clk_i, rst_i).
- Reset values: state IDLE, result_o 0, busy_o 0, done_o 0, iteration counter 0.
- busy_o and done_o are Moore outputs decoded from state.
- States: IDLE, CHECK, DIVIDE, FIX, DONE.
- In every state, div_en_i low forces next state to IDLE. result_o keeps its last value.
- IDLE with div_en_i high:
  - latch op_i, rs1_i, rs2_i;
  - go to CHECK.
  - Operand changes after this edge are ignored.
- CHECK, special cases (result written, go to DONE):
  - divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF: result 0x80000000. REM with the same operands: result 0.
- CHECK, otherwise:
  - load |dividend| and |divisor|; absolute value only for DIV/REM;
  - clear the 33-bit partial remainder;
  - counter = 31; go to DIVIDE.
- DIVIDE, each cycle:
  - shift {remainder, quotient} left 1, dividend MSB entering;
  - trial subtract the divisor; if non-negative, keep the difference and set quotient LSB.
  - When counter = 0 go to FIX, else decrement.
- FIX (signed ops only):
  - negate the quotient if operand signs differ;
  - negate the remainder if the dividend was negative.
  - Select quotient for DIV/DIVU, remainder for REM/REMU; register into result_o; go to DONE.
- DONE:
  - stays while div_en_i is high; done_o held;
  - a new operation requires div_en_i low for at least one cycle.

## Timing
- Edge numbering: edge 0 is the first rising edge sampling div_en_i = 1 in IDLE.
- Normal path:
  - edge 1 enters DIVIDE; edges 2..33 perform the 32 iterations; edge 34 enters DONE.
  - done_o and result_o are valid after edge 34.
- Special path: DONE entered at edge 1.
- Abort: div_en_i low at any edge returns to IDLE. done_o and busy_o fall after that edge.
- Reset mid-operation: immediate return to reset values, regardless of clock.
- Result width: all arithmetic is 33-bit internally; no output saturation beyond the RISC-V special cases.

## Structure
- Shared rv32m package holds:
  - op encodings (DIV/DIVU/REM/REMU);
  - state encoding; gray-style, IDLE = 000;
  - constants INT_MIN = 0x80000000 and ALL_ONES = 0xFFFFFFFF.
- One natural sub-module: div_step, a combinational single-iteration shift/trial-subtract. It is instantiated once and fed by the DIVIDE-state registers.

## Test plan
- DIV 20 / -3: result_o 0xFFFFFFFA with done_o rising after edge 34. REM with the same operands: 2.
- DIVU 0xFFFFFFFF / 2: result_o 0x7FFFFFFF. REMU with the same operands: 1.
- DIV 7 / 0: result_o 0xFFFFFFFF after edge 1, busy_o high for one cycle. REMU 7 / 0: result_o 7.
- DIV 0x80000000 / 0xFFFFFFFF: result_o 0x80000000 after edge 1. REM with the same operands: 0.
- Abort:
  - drop div_en_i at edge 10: IDLE next cycle, done_o never asserted;
  - re-enable with DIVU 100 / 7: result_o 14 after the full 35 edges.
- Reset and handshake:
  - assert rst_i asynchronously mid-DIVIDE: all outputs 0 immediately;
  - after release, DIV -9 / 2 gives -4 (0xFFFFFFFC), and REM with the same operands gives -1 (0xFFFFFFFF);
  - done_o stays high while div_en_i is held.
